// File: rtl/tx_pulser_ch.sv
// Per-channel transmit beamformer: a focal-zone delay LUT plus a delay/burst FSM driving a bipolar HV pulser.
// Start-to-first-pulse latency is D+2 cycles; all outputs are registered. Abort and reset force every output low.
module tx_pulser_ch #(
  parameter int ADDR_WD = 6,
  parameter int DLY_WD  = 12,
  parameter int HP_WD   = 8,
  parameter int NC_WD   = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [ADDR_WD-1:0] lut_addr,
  input  logic               lut_we,
  input  logic [DLY_WD-1:0]  lut_din,
  input  logic [ADDR_WD-1:0] zone_sel,
  input  logic [HP_WD-1:0]   half_period,
  input  logic [NC_WD-1:0]   num_cycles,
  input  logic               start,
  input  logic               abort,
  output logic               pulse_p,
  output logic               pulse_n,
  output logic               tx_en,
  output logic               busy,
  output logic               done
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    DELAY = 3'd2,
    POS   = 3'd3,
    NEG   = 3'd4,
    DEAD  = 3'd5
  } state_t;

  state_t             state_q, state_d;
  logic [DLY_WD-1:0]  dly_q, dly_d;
  logic [HP_WD-1:0]   hp_q, hp_d;
  logic [HP_WD-1:0]   ph_q, ph_d;
  logic [NC_WD-1:0]   cyc_q, cyc_d;
  logic               pulse_p_q, pulse_p_d;
  logic               pulse_n_q, pulse_n_d;
  logic               tx_en_q, tx_en_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  // Delay LUT: no reset. The LOAD-cycle read sees the pre-write contents, giving read-first semantics.
  logic [DLY_WD-1:0]  lut_mem [2**ADDR_WD];

  always_ff @(posedge clk) begin
    if (lut_we) begin
      lut_mem[lut_addr] <= lut_din;
    end
  end

  always_comb begin
    state_d = state_q;
    dly_d   = dly_q;
    hp_d    = hp_q;
    ph_d    = ph_q;
    cyc_d   = cyc_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          hp_d    = (half_period == '0) ? HP_WD'(1) : half_period;
          cyc_d   = num_cycles;
          state_d = LOAD;
        end
      end
      LOAD: begin
        dly_d   = lut_mem[zone_sel];
        state_d = DELAY;
      end
      DELAY: begin
        if (dly_q == '0) begin
          ph_d    = hp_q - HP_WD'(1);
          state_d = (cyc_q != '0) ? POS : DEAD;
        end else begin
          dly_d = dly_q - DLY_WD'(1);
        end
      end
      POS: begin
        if (ph_q == '0) begin
          ph_d    = hp_q - HP_WD'(1);
          state_d = NEG;
        end else begin
          ph_d = ph_q - HP_WD'(1);
        end
      end
      NEG: begin
        if (ph_q == '0) begin
          ph_d  = hp_q - HP_WD'(1);
          cyc_d = cyc_q - NC_WD'(1);
          state_d = (cyc_q == NC_WD'(1)) ? DEAD : POS;
        end else begin
          ph_d = ph_q - HP_WD'(1);
        end
      end
      DEAD: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (abort) begin
      state_d = IDLE;
    end
  end

  // Outputs are decoded from the next state so they line up with the state register.
  always_comb begin
    pulse_p_d = (state_d == POS);
    pulse_n_d = (state_d == NEG);
    tx_en_d   = (state_d == LOAD) || (state_d == DELAY) || (state_d == POS) || (state_d == NEG);
    busy_d    = (state_d != IDLE);
    done_d    = (state_d == DEAD);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      dly_q     <= '0;
      hp_q      <= '0;
      ph_q      <= '0;
      cyc_q     <= '0;
      pulse_p_q <= 1'b0;
      pulse_n_q <= 1'b0;
      tx_en_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      dly_q     <= dly_d;
      hp_q      <= hp_d;
      ph_q      <= ph_d;
      cyc_q     <= cyc_d;
      pulse_p_q <= pulse_p_d;
      pulse_n_q <= pulse_n_d;
      tx_en_q   <= tx_en_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign pulse_p = pulse_p_q;
  assign pulse_n = pulse_n_q;
  assign tx_en   = tx_en_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule
